// File: rtl/pattern_detector_pkg.sv
// Shared widths, FSM state and compare-mode encodings for the pattern search path.
package pattern_detector_pkg;

  localparam int DATA_W  = 64;
  localparam int PAT_W   = 32;
  localparam int NUM_POS = DATA_W - PAT_W + 1;
  localparam int OFS_W   = $clog2(NUM_POS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_FULL = 1'b0,
    MODE_MASK = 1'b1
  } mode_e;

endpackage

// File: rtl/pattern_window_row.sv
// One comparator row: a single A window against every B offset, combinational.
// Returns the per-offset hit vector, an any-hit flag and the lowest hitting offset.
module pattern_window_row
  import pattern_detector_pkg::*;
(
  input  logic [PAT_W-1:0]   i_win_a,
  input  logic [DATA_W-1:0]  i_b,
  input  logic               i_mode,
  input  logic [PAT_W-1:0]   i_mask,
  output logic [NUM_POS-1:0] o_hit_vec,
  output logic               o_hit,
  output logic [OFS_W-1:0]   o_hit_ofs
);

  logic [PAT_W-1:0] w_cmp_mask;

  // Full mode is simply a mask of all ones.
  assign w_cmp_mask = (i_mode == MODE_MASK) ? i_mask : {PAT_W{1'b1}};

  for (genvar j = 0; j < NUM_POS; j++) begin : g_col
    assign o_hit_vec[j] = ((i_b[j +: PAT_W] ^ i_win_a) & w_cmp_mask) == '0;
  end

  assign o_hit = |o_hit_vec;

  always_comb begin
    o_hit_ofs = '0;
    for (int j = NUM_POS - 1; j >= 0; j--) begin
      if (o_hit_vec[j]) o_hit_ofs = OFS_W'(j);
    end
  end

endmodule

// File: rtl/pattern_search_sequencer.sv
// Sequential pattern search: one A offset per cycle against all B offsets, result 2..34 cycles after accept.
// No new request until the result is taken (out_ready); abort cancels the transaction and clears results.
module pattern_search_sequencer
  import pattern_detector_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_stream_a,
  input  logic [DATA_W-1:0] data_stream_b,
  input  logic              mode_select,
  input  logic [PAT_W-1:0]  pattern_mask,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              match_found,
  output logic [OFS_W-1:0]  match_offset_a,
  output logic [OFS_W-1:0]  match_offset_b,
  output logic              busy
);

  state_e             r_state;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  mode_e              r_mode;
  logic [PAT_W-1:0]   r_mask;
  logic [OFS_W-1:0]   r_i;
  logic               r_found;
  logic [OFS_W-1:0]   r_ofs_a;
  logic [OFS_W-1:0]   r_ofs_b;

  logic [PAT_W-1:0]   w_win_a;
  logic [NUM_POS-1:0] w_hit_vec_unused;
  logic               w_hit;
  logic [OFS_W-1:0]   w_hit_ofs;

  assign w_win_a = PAT_W'(r_a >> r_i);

  pattern_window_row u_row (
    .i_win_a   (w_win_a),
    .i_b       (r_b),
    .i_mode    (r_mode),
    .i_mask    (r_mask),
    .o_hit_vec (w_hit_vec_unused),
    .o_hit     (w_hit),
    .o_hit_ofs (w_hit_ofs)
  );

  // in_ready is the only output with a combinational input path (abort).
  assign in_ready       = (r_state == IDLE) && !abort;
  assign out_valid      = (r_state == DONE);
  assign busy           = (r_state != IDLE);
  assign match_found    = r_found;
  assign match_offset_a = r_ofs_a;
  assign match_offset_b = r_ofs_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= MODE_FULL;
      r_mask  <= '0;
      r_i     <= '0;
      r_found <= 1'b0;
      r_ofs_a <= '0;
      r_ofs_b <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && !abort) begin
            r_a     <= data_stream_a;
            r_b     <= data_stream_b;
            r_mode  <= mode_e'(mode_select);
            r_mask  <= pattern_mask;
            r_i     <= '0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (abort) begin
            r_found <= 1'b0;
            r_ofs_a <= '0;
            r_ofs_b <= '0;
            r_state <= IDLE;
          end else if (w_hit) begin
            r_found <= 1'b1;
            r_ofs_a <= r_i;
            r_ofs_b <= w_hit_ofs;
            r_state <= DONE;
          end else if (r_i == OFS_W'(NUM_POS - 1)) begin
            r_found <= 1'b0;
            r_ofs_a <= '0;
            r_ofs_b <= '0;
            r_state <= DONE;
          end else begin
            r_i <= r_i + OFS_W'(1);
          end
        end
        DONE: begin
          if (abort) begin
            r_found <= 1'b0;
            r_ofs_a <= '0;
            r_ofs_b <= '0;
            r_state <= IDLE;
          end else if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_search_sequencer.sv
// Directed bench for pattern_search_sequencer: driver pushes hand-computed results into a
// scoreboard queue, a negedge monitor pops and compares whenever out_valid appears.
module tb_pattern_search_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] data_stream_a = '0;
  logic [63:0] data_stream_b = '0;
  logic        mode_select = 1'b0;
  logic [31:0] pattern_mask = '0;
  logic        abort = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        match_found;
  logic [5:0]  match_offset_a;
  logic [5:0]  match_offset_b;
  logic        busy;

  pattern_search_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .data_stream_a  (data_stream_a),
    .data_stream_b  (data_stream_b),
    .mode_select    (mode_select),
    .pattern_mask   (pattern_mask),
    .abort          (abort),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .match_found    (match_found),
    .match_offset_a (match_offset_a),
    .match_offset_b (match_offset_b),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       found;
    logic [5:0] oa;
    logic [5:0] ob;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   mon_active = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: first cycle of out_valid checks timing and values, later cycles check stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else begin
      if (out_valid && !mon_active) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 1'b0);
        end else begin
          cur = sb.pop_front();
          mon_active = 1'b1;
          chk("out_valid_cycle", cyc, cur.cyc);
          chk("match_found", match_found, cur.found);
          chk("match_offset_a", match_offset_a, cur.oa);
          chk("match_offset_b", match_offset_b, cur.ob);
        end
      end else if (out_valid && mon_active) begin
        chk("hold_found", match_found, cur.found);
        chk("hold_offset_a", match_offset_a, cur.oa);
        chk("hold_offset_b", match_offset_b, cur.ob);
      end
      if (out_valid) chk("in_ready_while_valid", in_ready, 1'b0);
      if (out_valid && out_ready) mon_active = 1'b0;
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic m,
                      input logic [31:0] mk, input bit push, input logic f,
                      input logic [5:0] oa, input logic [5:0] ob, input int lat);
    int   n;
    exp_t e;
    @(posedge clk); #1;
    in_valid      = 1'b1;
    data_stream_a = a;
    data_stream_b = b;
    mode_select   = m;
    pattern_mask  = mk;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_ready", in_ready, 1'b1);
    if (push) begin
      e.found = f;
      e.oa    = oa;
      e.ob    = ob;
      e.cyc   = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    // Scramble inputs after accept; only the latched copies may matter.
    in_valid      = 1'b0;
    data_stream_a = ~a;
    data_stream_b = ~b;
    mode_select   = ~m;
    pattern_mask  = ~mk;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || mon_active || sb.size() != 0) && n < 100);
    chk(name, busy, 1'b0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  in_ready,       1'b1);
    chk({tag, "_out_valid"}, out_valid,      1'b0);
    chk({tag, "_busy"},      busy,           1'b0);
    chk({tag, "_found"},     match_found,    1'b0);
    chk({tag, "_ofs_a"},     match_offset_a, 6'd0);
    chk({tag, "_ofs_b"},     match_offset_b, 6'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #2 chk_idle("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    // Early hit: A[31:0]=DEADBEEF found at B offset 8.
    send(64'h0000_0000_DEAD_BEEF, 64'h0000_00DE_ADBE_EF00, 1'b0, 32'h0, 1'b1, 1'b1, 6'd0, 6'd8, 2);
    wait_idle("early_drain");
    // Late hit: only A window 32 is nonzero; B has no all-zero window.
    send(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0, 32'h0, 1'b1, 1'b1, 6'd32, 6'd0, 34);
    wait_idle("late_drain");
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 32'h0, 1'b1, 1'b0, 6'd0, 6'd0, 34);
    wait_idle("nomatch_drain");
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 32'h0, 1'b1, 1'b1, 6'd0, 6'd0, 2);
    wait_idle("mask0_drain");

    // Backpressure: result held 10 cycles, in_valid held but must not be accepted.
    out_ready = 1'b0;
    send(64'h0000_0000_DEAD_BEEF, 64'h0000_00DE_ADBE_EF00, 1'b0, 32'h0, 1'b1, 1'b1, 6'd0, 6'd8, 2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    chk("bp_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    in_valid      = 1'b1;
    data_stream_a = 64'h1;
    data_stream_b = 64'h1;
    repeat (9) @(posedge clk);
    #1;
    chk("bp_still_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", in_ready, 1'b1);
    chk("bp_busy_after", busy, 1'b0);
    chk("bp_out_valid_after", out_valid, 1'b0);
    wait_idle("bp_drain");

    // Abort in SCAN at T+5 of a no-match scan: idle at T+6, results cleared, no result.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 32'h0, 1'b0, 1'b0, 6'd0, 6'd0, 0);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk_idle("abort_scan");
    repeat (40) @(negedge clk);
    chk("abort_no_result", out_valid, 1'b0);

    // Abort together with in_valid in IDLE: no accept.
    @(posedge clk); #1;
    in_valid = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    chk("abort_idle_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    abort    = 1'b0;
    @(negedge clk);
    chk("abort_idle_busy", busy, 1'b0);

    // Mask mode: only the upper 16 bits of each window count; 0x1234 sits at B offset 8.
    send(64'h0000_0000_1234_5678, 64'h0000_0012_3400_0000, 1'b1, 32'hFFFF_0000, 1'b1, 1'b1, 6'd0, 6'd8, 2);
    wait_idle("mask_drain");

    // Reset at T+10 of a late-hit scan discards it; next transaction has normal latency.
    send(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0, 32'h0, 1'b0, 1'b0, 6'd0, 6'd0, 0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_idle("midscan_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midscan_no_result", out_valid, 1'b0);
    send(64'h0000_0000_DEAD_BEEF, 64'h0000_00DE_ADBE_EF00, 1'b0, 32'h0, 1'b1, 1'b1, 6'd0, 6'd8, 2);
    wait_idle("after_reset_drain");

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_search_sequencer.md
# pattern_search_sequencer

Time-multiplexed search controller for the pattern detection path. It accepts one pair of 64-bit stream words per transaction over a valid/ready handshake and latches the mode and mask. It then sequences a shared single-row comparator across the 33 stream-A window offsets, one offset per cycle, and returns the first matching (offset_a, offset_b) pair over a valid/ready result handshake. It replaces the full 33×33 single-cycle comparator array where area or timing at 160 MHz forbids it.

## Interface
- DATA_W, 64, stream word width
- PAT_W, 32, pattern window width; NUM_POS = DATA_W-PAT_W+1 (33), OFS_W = $clog2(NUM_POS) (6)
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid & in_ready
- data_stream_a  input  DATA_W  stream A word
- data_stream_b  input  DATA_W  stream B word
- mode_select  input  1  0 = full compare, 1 = mask-based
- pattern_mask  input  PAT_W  compare mask, used when mode_select=1
- abort  input  1  synchronous cancel of the current transaction
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid & out_ready
- match_found  output  1  at least one window pair matched
- match_offset_a  output  OFS_W  LSB offset i of the matching A window
- match_offset_b  output  OFS_W  LSB offset j of the matching B window
- busy  output  1  state ≠ IDLE

## Operation
- FSM states are IDLE, SCAN and DONE. Reset enters IDLE.
- IDLE: in_ready=1. On accept, latch A, B, mode and mask. Clear the offset counter i to 0. Go to SCAN. If abort=1 in the same cycle, the request is not accepted: in_ready is forced to 0.
- SCAN: compare window A[i +: PAT_W] against all NUM_POS windows B[j +: PAT_W] in parallel.
  - Mode 0 compares all bits. Mode 1 compares (a & mask) == (b & mask).
  - On any hit: register found=1, offset_a=i, offset_b = lowest hitting j. Go to DONE.
  - On a miss with i == NUM_POS-1: register found=0 and both offsets 0. Go to DONE.
  - Otherwise increment i.
- Result priority is the lowest i first, then the lowest j.
- DONE: out_valid=1. All result outputs are held stable until out_ready. On the handshake, go to IDLE.
- abort in SCAN or DONE: go to IDLE on the next edge with no result handshake. Result registers clear to 0.
- Inputs that change while in SCAN or DONE have no effect, because only latched copies are used.
- Reset values: in_ready=1 (IDLE), out_valid=0, match_found=0, match_offset_a=0, match_offset_b=0, busy=0. Asynchronous reset mid-scan discards the transaction immediately.

## Timing
- Accept edge ends cycle T. Offset i=k is compared in cycle T+1+k.
- A hit at i=k gives out_valid high from cycle T+2+k. The minimum latency is 2 cycles.
- No match gives out_valid at T+2+NUM_POS-1 = T+34.
- in_ready is 0 from T+1 until the cycle after the result handshake. There is no overlap: throughput is one transaction per (latency + 1) cycles minimum.
- All outputs are registered or decoded from state only. There is no combinational input-to-output path except in_ready, which is gated by abort.

## Structure
- Shared package pattern_detector_pkg holds:
  - DATA_W, PAT_W, NUM_POS, OFS_W
  - typedef enum for the FSM state (IDLE, SCAN, DONE)
  - typedef enum for the mode (MODE_FULL=0, MODE_MASK=1)
- Sub-module pattern_window_row is combinational. It takes a window A, the full B word, the mode and the mask. It returns a NUM_POS-bit hit vector, a hit flag and the priority-encoded lowest j.
- The top level contains the FSM, the offset counter, the input latches and the result registers.

## Test plan
- Early hit: A=64'h0000_0000_DEAD_BEEF, B=64'h0000_00DE_ADBE_EF00, mode 0 -> out_valid at T+2, found=1, offset_a=0, offset_b=8.
- Late hit: A=64'h8000_0000_0000_0000, B=64'hFFFF_FFFF_8000_0000, mode 0 -> out_valid at T+34, found=1, offset_a=32, offset_b=0.
- No match: A=64'hFFFF_FFFF_FFFF_FFFF, B=0, mode 0 -> out_valid at T+34, found=0, both offsets 0. Same data with mode 1 and mask=0 -> T+2, found=1, offsets 0/0.
- Backpressure: after the early-hit case, hold out_ready=0 for 10 cycles -> out_valid and the results stay stable, in_ready=0, and a held in_valid is not accepted. in_ready returns to 1 in the cycle after out_ready=1.
- Abort: pulse abort at T+5 during the no-match case -> no out_valid ever, busy=0 and in_ready=1 at T+6, results 0. Also assert abort together with in_valid in IDLE -> no accept.
- Reset mid-scan: drop rst_n at T+10 -> all outputs take their reset values immediately. After release, the next transaction completes with normal latency.
